// File: rtl/isolator_sr_controller.sv
// Isolator shift-register chain driver: serialises slot control words, deserialises return status.
// Latency: frame = 1 LOAD + FRAME_BITS SHIFT + SRCLK_CYCLES LATCH + GAP_CYCLES GAP; status valid on LATCH entry.
// No backpressure: free-running while enable_i is high. Optional ISO_SR_AOVF_STICKY_EN adds sticky overflow flags.
module isolator_sr_controller #(
  parameter int N_OUT        = 4,
  parameter int N_IN         = 8,
  parameter int FRAME_BITS   = 8,
  parameter int SRCLK_CYCLES = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,        // asynchronous, active-low
  input  logic             enable_i,
  input  logic [N_OUT-1:0] dmcs_par_i,
  input  logic [N_OUT-1:0] amcs_par_i,
  input  logic [N_OUT-1:0] clksel_par_i,
  input  logic             dirchan_i,
  input  logic             aovf_i,
`ifdef ISO_SR_AOVF_STICKY_EN
  input  logic             aovf_clear_i,
  output logic [N_IN-1:0]  aovf_sticky_o,
`endif
  output logic             dmcs_o,
  output logic             amcs_o,
  output logic             clksel_o,
  output logic             srclk_o,
  output logic [N_IN-1:0]  dirchan_par_o,
  output logic [N_IN-1:0]  aovf_par_o,
  output logic             status_valid_o,
  output logic             busy_o
);

  localparam int CW = $clog2(FRAME_BITS + SRCLK_CYCLES + GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [FRAME_BITS-1:0] dmcs_sr_q, amcs_sr_q, clksel_sr_q;
  logic [FRAME_BITS-1:0] dmcs_word, amcs_word, clksel_word;
  logic                  dmcs_q, amcs_q, clksel_q, srclk_q, status_q;
  logic [N_IN-1:0]       dir_rx_q, aovf_rx_q, dir_par_q, aovf_par_q;
  logic [N_IN-1:0]       dir_rx_nx, aovf_rx_nx;
  logic                  latch_ev;

  // Outgoing words zero-padded at the MSB end so the data bits leave last.
  assign dmcs_word   = FRAME_BITS'(dmcs_par_i);
  assign amcs_word   = FRAME_BITS'(amcs_par_i);
  assign clksel_word = FRAME_BITS'(clksel_par_i);

  // Receive registers shift LSB-in; the next value is also what gets published on LATCH entry.
  assign dir_rx_nx  = {dir_rx_q[N_IN-2:0], dirchan_i};
  assign aovf_rx_nx = {aovf_rx_q[N_IN-2:0], aovf_i};
  assign latch_ev   = (state_q == SHIFT) && (state_d == LATCH);

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a frame always runs to completion once LOAD is entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable_i) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (cnt_q == CW'(FRAME_BITS - 1)) state_d = LATCH;
      LATCH: begin
        if (cnt_q == CW'(SRCLK_CYCLES - 1)) begin
          if (GAP_CYCLES != 0) state_d = GAP;
          else                 state_d = enable_i ? LOAD : IDLE;
        end
      end
      GAP:   if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = enable_i ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: every pin except busy comes straight from a flop so srclk cannot glitch.
  always_comb begin
    busy_o         = (state_q != IDLE);
    dmcs_o         = dmcs_q;
    amcs_o         = amcs_q;
    clksel_o       = clksel_q;
    srclk_o        = srclk_q;
    status_valid_o = status_q;
    dirchan_par_o  = dir_par_q;
    aovf_par_o     = aovf_par_q;
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else                         cnt_q <= cnt_q + 1'b1;
  end

  // Shift datapath: load words, stream MSB first, capture return bits, publish on LATCH entry.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dmcs_sr_q   <= '0;
      amcs_sr_q   <= '0;
      clksel_sr_q <= '0;
      dmcs_q      <= 1'b0;
      amcs_q      <= 1'b0;
      clksel_q    <= 1'b0;
      srclk_q     <= 1'b0;
      status_q    <= 1'b0;
      dir_rx_q    <= '0;
      aovf_rx_q   <= '0;
      dir_par_q   <= '0;
      aovf_par_q  <= '0;
    end else begin
      srclk_q  <= (state_d == LATCH);
      status_q <= latch_ev;
      dmcs_q   <= 1'b0;
      amcs_q   <= 1'b0;
      clksel_q <= 1'b0;
      if (state_q == LOAD) begin
        dmcs_q      <= dmcs_word[FRAME_BITS-1];
        amcs_q      <= amcs_word[FRAME_BITS-1];
        clksel_q    <= clksel_word[FRAME_BITS-1];
        dmcs_sr_q   <= dmcs_word << 1;
        amcs_sr_q   <= amcs_word << 1;
        clksel_sr_q <= clksel_word << 1;
      end
      if (state_q == SHIFT) begin
        dir_rx_q  <= dir_rx_nx;
        aovf_rx_q <= aovf_rx_nx;
        if (state_d == SHIFT) begin
          dmcs_q      <= dmcs_sr_q[FRAME_BITS-1];
          amcs_q      <= amcs_sr_q[FRAME_BITS-1];
          clksel_q    <= clksel_sr_q[FRAME_BITS-1];
          dmcs_sr_q   <= dmcs_sr_q << 1;
          amcs_sr_q   <= amcs_sr_q << 1;
          clksel_sr_q <= clksel_sr_q << 1;
        end
      end
      if (latch_ev) begin
        dir_par_q  <= dir_rx_nx;
        aovf_par_q <= aovf_rx_nx;
      end
    end
  end

`ifdef ISO_SR_AOVF_STICKY_EN
  logic [N_IN-1:0] sticky_q;

  // Sticky overflow accumulator; a clear coinciding with a status update keeps only the new word.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)          sticky_q <= '0;
    else if (latch_ev)     sticky_q <= (aovf_clear_i ? '0 : sticky_q) | aovf_rx_nx;
    else if (aovf_clear_i) sticky_q <= '0;
  end

  assign aovf_sticky_o = sticky_q;
`endif

endmodule

// File: doc/isolator_sr_controller.md
Name: isolator_sr_controller

Overview:
- FPGA-side driver for the isolator board's 74xx shift-register chain.
- Packs the per-slot control words (DMCS, AMCS, CLKSEL) into serial streams on dmcs/amcs/clksel and generates srclk.
- Unpacks the returned dirchan/aovf streams into per-slot DIR/CHAN and overflow flags.
- Sits directly upstream of the isolator board; runs continuously on the isolator master clock (mclk).

Parameters:
- N_OUT, 4, bits per outgoing word (one per slot).
- N_IN, 8, bits per incoming word.
- FRAME_BITS, 8, shift cycles per frame; must be >= max(N_OUT, N_IN).
- SRCLK_CYCLES, 1, cycles srclk is held high per frame.
- GAP_CYCLES, 2, idle cycles between frames (0 allowed).

Ports:
- clk  in  1  mclk domain; also drives isolator clk_ser.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run continuous frames while high.
- dmcs_par  in  N_OUT  slot DMCS chip-selects.
- amcs_par  in  N_OUT  slot AMCS chip-selects.
- clksel_par  in  N_OUT  slot oscillator select (1 = clk1 / 24.576 MHz).
- dmcs  out  1  serial DMCS stream.
- amcs  out  1  serial AMCS stream.
- clksel  out  1  serial CLKSEL stream.
- srclk  out  1  parallel latch/load strobe to isolator.
- dirchan  in  1  serial {chan[3:0], dir[3:0]} return stream.
- aovf  in  1  serial {aovfr3, aovfl3, ..., aovfr0, aovfl0} return stream.
- dirchan_par  out  N_IN  last received dirchan word.
- aovf_par  out  N_IN  last received aovf word.
- status_valid  out  1  one-cycle pulse when *_par update.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0, including srclk, serial outs, *_par, status_valid and busy.
- FSM states: IDLE, LOAD, SHIFT, LATCH, GAP.
- IDLE -> LOAD when enable=1.
- LOAD (1 cycle):
  - Capture dmcs_par/amcs_par/clksel_par into FRAME_BITS shift registers, zero-padded at the MSB end.
  - Parallel-input changes after LOAD are ignored until the next frame's LOAD.
- SHIFT (FRAME_BITS cycles, counter 0..FRAME_BITS-1):
  - Serial outputs are registered and drive the register MSB; shift left each cycle, so data goes out MSB first.
  - The last N_OUT bits shifted are the data word.
  - dirchan/aovf are sampled at the clk edge ending each SHIFT cycle and shifted into the receive registers LSB-in.
  - After the frame, the receive register holds the last N_IN sampled bits; the first-sampled bit lands in the MSB when FRAME_BITS=N_IN.
- LATCH (SRCLK_CYCLES cycles):
  - srclk=1; serial outputs 0.
  - The cycle LATCH is entered: dirchan_par/aovf_par take the receive registers, and status_valid=1 for exactly that cycle.
- GAP (GAP_CYCLES cycles; skipped if 0): srclk=0. At the end, go to LOAD if enable=1, else IDLE.
- Frame period = 1 + FRAME_BITS + SRCLK_CYCLES + GAP_CYCLES; 12 cycles at defaults.
- Return data in frame k reflects the isolator parallel state loaded by frame k-1's srclk. The first frame after reset returns whatever the isolator held; software discards the first status_valid.
- Serial outputs and srclk are 0 in IDLE, LOAD, LATCH and GAP.
- busy = 1 in LOAD, SHIFT, LATCH and GAP; 0 in IDLE.
- enable deasserted mid-frame: the frame completes (including LATCH and GAP), then IDLE. There are no partial frames.
- Reset asserted mid-frame: immediate IDLE; srclk never glitches high; *_par cleared.

Optional Feature:
- Macro: ISO_SR_AOVF_STICKY_EN.
- When defined, adds:
  - input aovf_clear (1 bit);
  - output aovf_sticky (N_IN bits).
- On each status_valid, aovf_sticky |= received aovf word.
- aovf_clear=1 zeroes aovf_sticky on the next edge. If it coincides with status_valid, the result equals that frame's aovf word (clear then OR).
- aovf_sticky resets to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset values: hold reset=0 with enable=1 -> all outputs 0, busy=0.
- Idle startup: release reset with enable=0 -> stays IDLE; srclk stays 0 for 100 cycles.
- Outgoing bit order: enable=1, dmcs_par=4'b1010, amcs_par=4'b0001, clksel_par=4'b1111.
  - Over the 8 SHIFT cycles, dmcs = 0,0,0,0,1,0,1,0; amcs = 0,0,0,0,0,0,0,1; clksel = 0,0,0,0,1,1,1,1.
  - srclk high 1 cycle, then 2 GAP cycles; frame period 12.
- Return path: drive the dirchan bit sequence 1,0,1,1,0,0,1,0 during SHIFT -> dirchan_par=8'hB2 with a one-cycle status_valid on LATCH entry. aovf all-1s -> aovf_par=8'hFF.
- Mid-frame events:
  - Change dmcs_par during SHIFT -> current frame unchanged; new value appears in the next frame.
  - Drop enable in SHIFT -> frame completes, then busy=0.
  - Assert reset during LATCH -> srclk=0 immediately.
- Sticky overflow (ISO_SR_AOVF_STICKY_EN): frames with aovf 8'h01 then 8'h40 -> aovf_sticky=8'h41. Pulse aovf_clear -> 0. Clear coincident with an 8'h02 frame -> 8'h02.
